// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler.
// One neuron slot is updated per enabled cycle in a round-robin sweep. Current
// injections accumulate per slot and are folded into the membrane at that
// slot's next update. Each slot has a writable firing threshold.
// Optional feature: define LIF_REFRACTORY_EN to hold a slot silent for REFRAC
// updates after it fires.
module lif_scheduler #(
  parameter int unsigned NSLOT      = 8,
  parameter int unsigned LEAK_SHIFT = 1,
  parameter int unsigned REFRAC     = 2,
  parameter logic [7:0]  THRESH_RST = 8'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_idx,
  input  logic [7:0] in_current,
  output logic       in_ready,
  input  logic       cfg_we,
  input  logic [2:0] cfg_idx,
  input  logic [7:0] cfg_thresh,
  output logic [2:0] slot,
  output logic [7:0] spike,
  output logic [7:0] state,
  output logic       sweep_done
);

  localparam logic [2:0] LastSlot = 3'(NSLOT - 1);

  logic [2:0] slot_q, slot_d;
  logic [7:0] spike_q, spike_d;
  logic [7:0] state_q, state_d;
  logic       done_q, done_d;

  logic [7:0] v_q   [NSLOT];
  logic [7:0] v_d   [NSLOT];
  logic [7:0] acc_q [NSLOT];
  logic [7:0] acc_d [NSLOT];
  logic [7:0] th_q  [NSLOT];
  logic [7:0] th_d  [NSLOT];

  logic [7:0] v_cur, acc_cur, th_cur, leaked, vn, v_new;
  logic [8:0] sum;
  logic       fire;
  logic       inj_ok;

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned RcW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
  logic [RcW-1:0] rc_q [NSLOT];
  logic [RcW-1:0] rc_d [NSLOT];
  logic [RcW-1:0] rc_cur;
  logic           refr;
`else
  logic unused_refrac;
  assign unused_refrac = |REFRAC;
`endif

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // The slot under update refuses injections so its accumulator is never both read and added to.
  assign in_ready = !rst_n || !(en && (in_idx == slot_q));
  assign inj_ok   = in_valid && in_ready;

  // Select the current slot's state and compute its post-update membrane value.
  always_comb begin
    v_cur   = '0;
    acc_cur = '0;
    th_cur  = '0;
`ifdef LIF_REFRACTORY_EN
    rc_cur  = '0;
`endif
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_q == 3'(i)) begin
        v_cur   = v_q[i];
        acc_cur = acc_q[i];
        th_cur  = th_q[i];
`ifdef LIF_REFRACTORY_EN
        rc_cur  = rc_q[i];
`endif
      end
    end
    leaked = v_cur - (v_cur >> LEAK_SHIFT);
    sum    = {1'b0, leaked} + {1'b0, acc_cur};
    vn     = sum[8] ? 8'hFF : sum[7:0];
`ifdef LIF_REFRACTORY_EN
    refr   = (rc_cur != '0);
    fire   = !refr && (vn >= th_cur);
    v_new  = (refr || fire) ? 8'h00 : vn;
`else
    fire   = (vn >= th_cur);
    v_new  = fire ? 8'h00 : vn;
`endif
  end

  // Per-slot next state: update of the current slot, injections and threshold writes.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      v_d[i]   = v_q[i];
      acc_d[i] = acc_q[i];
      th_d[i]  = th_q[i];
`ifdef LIF_REFRACTORY_EN
      rc_d[i]  = rc_q[i];
`endif
      if (en && (slot_q == 3'(i))) begin
        v_d[i]   = v_new;
        acc_d[i] = '0;
`ifdef LIF_REFRACTORY_EN
        if (refr) begin
          rc_d[i] = rc_q[i] - 1'b1;
        end else if (fire) begin
          rc_d[i] = RcW'(REFRAC);
        end
`endif
      end else if (inj_ok && (in_idx == 3'(i))) begin
        acc_d[i] = sat_add8(acc_q[i], in_current);
      end
      // th_q feeds this cycle's update, so a same-cycle write only affects later updates.
      if (cfg_we && (cfg_idx == 3'(i))) begin
        th_d[i] = cfg_thresh;
      end
    end
  end

  // Sweep pointer and registered outputs.
  always_comb begin
    slot_d  = slot_q;
    spike_d = '0;
    state_d = state_q;
    done_d  = 1'b0;
    if (en) begin
      slot_d  = (slot_q == LastSlot) ? 3'd0 : slot_q + 3'd1;
      state_d = v_new;
      done_d  = (slot_q == LastSlot);
      if (fire) begin
        spike_d = 8'b1 << slot_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      spike_q <= '0;
      state_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
        th_q[i]  <= THRESH_RST;
`ifdef LIF_REFRACTORY_EN
        rc_q[i]  <= '0;
`endif
      end
    end else begin
      slot_q  <= slot_d;
      spike_q <= spike_d;
      state_q <= state_d;
      done_q  <= done_d;
      for (int i = 0; i < NSLOT; i++) begin
        v_q[i]   <= v_d[i];
        acc_q[i] <= acc_d[i];
        th_q[i]  <= th_d[i];
`ifdef LIF_REFRACTORY_EN
        rc_q[i]  <= rc_d[i];
`endif
      end
    end
  end

  assign slot       = slot_q;
  assign spike      = spike_q;
  assign state      = state_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: directed scenarios plus a random run,
// all compared against a slot-array reference model of the neuron rules.
module tb_lif_scheduler;

  localparam int NSLOT      = 8;
  localparam int LEAK_SHIFT = 1;
  localparam int REFRAC     = 2;
  localparam logic [7:0] THRESH_RST = 8'h7F;
`ifdef LIF_REFRACTORY_EN
  localparam bit RefrEn = 1'b1;
`else
  localparam bit RefrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [2:0] in_idx;
  logic [7:0] in_current;
  logic       in_ready;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [7:0] cfg_thresh;
  logic [2:0] slot;
  logic [7:0] spike;
  logic [7:0] state;
  logic       sweep_done;

  lif_scheduler #(
    .NSLOT      (NSLOT),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC),
    .THRESH_RST (THRESH_RST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_idx     (in_idx),
    .in_current (in_current),
    .in_ready   (in_ready),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_thresh (cfg_thresh),
    .slot       (slot),
    .spike      (spike),
    .state      (state),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integer arrays, one entry per neuron.
  int         m_v   [NSLOT];
  int         m_acc [NSLOT];
  int         m_th  [NSLOT];
  int         m_rc  [NSLOT];
  int         m_slot;
  logic [7:0] m_spike;
  logic [7:0] m_state;
  logic       m_done;
  logic       m_ready;
  logic       obs_ready;

  task automatic model_reset();
    for (int i = 0; i < NSLOT; i++) begin
      m_v[i] = 0; m_acc[i] = 0; m_th[i] = int'(THRESH_RST); m_rc[i] = 0;
    end
    m_slot = 0; m_spike = '0; m_state = '0; m_done = 1'b0; m_ready = 1'b1;
  endtask

  // Apply one clock's worth of the neuron rules to the model, using current inputs.
  task automatic model_step();
    int s, vn, idx;
    idx     = int'(in_idx);
    m_ready = !(en && idx == m_slot);
    if (en) begin
      s       = m_slot;
      m_done  = (s == NSLOT - 1);
      m_spike = '0;
      if (RefrEn && m_rc[s] > 0) begin
        m_rc[s]  = m_rc[s] - 1;
        m_v[s]   = 0;
        m_acc[s] = 0;
        m_state  = '0;
      end else begin
        vn = m_v[s] - m_v[s] / (1 << LEAK_SHIFT) + m_acc[s];
        if (vn > 255) vn = 255;
        m_acc[s] = 0;
        if (vn >= m_th[s]) begin
          m_spike = 8'(1 << s);
          m_v[s]  = 0;
          m_rc[s] = REFRAC;
          m_state = '0;
        end else begin
          m_v[s]  = vn;
          m_state = 8'(vn);
        end
      end
      m_slot = (s + 1) % NSLOT;
    end else begin
      m_spike = '0;
      m_done  = 1'b0;
    end
    if (in_valid && m_ready && idx < NSLOT) begin
      m_acc[idx] = m_acc[idx] + int'(in_current);
      if (m_acc[idx] > 255) m_acc[idx] = 255;
    end
    if (cfg_we && int'(cfg_idx) < NSLOT) m_th[int'(cfg_idx)] = int'(cfg_thresh);
  endtask

  // Advance one clock; leaves time at 1 unit after the rising edge.
  task automatic tick();
    #1;
    obs_ready = in_ready;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_to(input int target);
    en = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < NSLOT && m_slot != target; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; in_idx = 3'd0; in_current = 8'hFF;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_thresh = 8'h01;
    #1;
    n_checks++;
    if ({slot, spike, state, sweep_done} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got slot=%0d spike=%h state=%h done=%b, want all 0",
               slot, spike, state, sweep_done);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({slot, spike, state, sweep_done} !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_held: got slot=%0d spike=%h state=%h done=%b, want all 0",
               slot, spike, state, sweep_done);
    end
    in_valid = 1'b0; cfg_we = 1'b0; en = 1'b0;
    rst_n = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if ({slot, spike, state, sweep_done} !== {3'(m_slot), m_spike, m_state, m_done}) begin
      n_errors++;
      $display("FAIL reset_en_low_hold: got slot=%0d spike=%h state=%h done=%b, want %0d %h %h %b",
               slot, spike, state, sweep_done, m_slot, m_spike, m_state, m_done);
    end
  endtask

  task automatic test_sweep();
    en = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++;
      if ({slot, spike, state, sweep_done} !== {3'(m_slot), m_spike, m_state, m_done} ||
          sweep_done !== (k == 7 || k == 15) || slot !== 3'((k + 1) % NSLOT)) begin
        n_errors++;
        $display("FAIL sweep[%0d]: got slot=%0d spike=%h state=%h done=%b, want %0d %h %h %b",
                 k, slot, spike, state, sweep_done, m_slot, m_spike, m_state, m_done);
      end
    end
  endtask

  task automatic test_fire();
    idle_to(0);
    in_valid = 1'b1; in_idx = 3'd2; in_current = 8'h80;
    tick();
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL fire_in_ready: got %b, want 1", obs_ready);
    end
    in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (spike !== 8'h04 || state !== 8'h00 ||
        {slot, spike, state, sweep_done} !== {3'(m_slot), m_spike, m_state, m_done}) begin
      n_errors++;
      $display("FAIL fire_slot2: got spike=%h state=%h slot=%0d, want spike=04 state=00 slot=%0d",
               spike, state, slot, m_slot);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] want [2];
    want[0] = 8'h40; want[1] = 8'h60;
    for (int r = 0; r < 2; r++) begin
      idle_to(0);
      in_valid = 1'b1; in_idx = 3'd3; in_current = 8'h40;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (state !== want[r] || spike !== 8'h00 || state !== m_state) begin
        n_errors++;
        $display("FAIL accumulate[%0d]: got state=%h spike=%h, want state=%h spike=00",
                 r, state, spike, want[r]);
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_to(4);
    in_valid = 1'b1; in_idx = 3'd4; in_current = 8'h30;
    tick();
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_refused: got in_ready=%b, want 0", obs_ready);
    end
    tick();
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_accepted: got in_ready=%b, want 1", obs_ready);
    end
    in_valid = 1'b0;
    idle_to(4);
    tick();
    n_checks++;
    if (state !== 8'h30 || spike !== 8'h00 || state !== m_state) begin
      n_errors++;
      $display("FAIL b2b_count_once: got state=%h spike=%h, want state=30 spike=00", state, spike);
    end
  endtask

  task automatic test_refractory();
    logic [7:0] want;
    for (int r = 0; r < 4; r++) begin
      idle_to(0);
      in_valid = 1'b1; in_idx = 3'd1; in_current = 8'hFF;
      tick();
      in_valid = 1'b0;
      tick();
      want = (r == 0 || !RefrEn || r == 3) ? 8'h02 : 8'h00;
      n_checks++;
      if (spike !== want || spike !== m_spike) begin
        n_errors++;
        $display("FAIL refractory[%0d]: got spike=%h, want %h", r, spike, want);
      end
    end
  endtask

  task automatic test_threshold_reset();
    idle_to(0);
    in_valid = 1'b1; in_idx = 3'd5; in_current = 8'h10;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    // Write lands in the same cycle as slot 5's update; the old threshold must apply.
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_thresh = 8'h10;
    tick();
    cfg_we = 1'b0;
    n_checks++;
    if (spike !== 8'h00 || state !== 8'h10) begin
      n_errors++;
      $display("FAIL cfg_same_cycle: got spike=%h state=%h, want spike=00 state=10", spike, state);
    end
    idle_to(0);
    in_valid = 1'b1; in_idx = 3'd5; in_current = 8'h10;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (spike !== 8'h20 || state !== 8'h00 || spike !== m_spike) begin
      n_errors++;
      $display("FAIL cfg_thresh_fire: got spike=%h state=%h, want spike=20 state=00", spike, state);
    end
    // Mid-sweep reset with a pending injection into slot 5.
    idle_to(2);
    in_valid = 1'b1; in_idx = 3'd5; in_current = 8'h70;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({slot, spike, state, sweep_done} !== 19'd0) begin
      n_errors++;
      $display("FAIL midsweep_reset: got slot=%0d spike=%h state=%h done=%b, want all 0",
               slot, spike, state, sweep_done);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    in_valid = 1'b1; in_idx = 3'd5; in_current = 8'h10;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (spike !== 8'h00 || state !== 8'h10 || slot !== 3'd6) begin
      n_errors++;
      $display("FAIL thresh_restored: got spike=%h state=%h slot=%0d, want spike=00 state=10 slot=6",
               spike, state, slot);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      en         = ($urandom_range(0, 3) != 0);
      in_valid   = 1'($urandom_range(0, 1));
      in_idx     = 3'($urandom_range(0, 7));
      in_current = 8'($urandom_range(0, 255));
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_idx    = 3'($urandom_range(0, 7));
      cfg_thresh = 8'($urandom_range(32, 255));
      tick();
      n_checks++;
      if (obs_ready !== m_ready ||
          {slot, spike, state, sweep_done} !== {3'(m_slot), m_spike, m_state, m_done}) begin
        n_errors++;
        $display("FAIL random[%0d]: got rdy=%b slot=%0d spike=%h state=%h done=%b, want %b %0d %h %h %b",
                 k, obs_ready, slot, spike, state, sweep_done,
                 m_ready, m_slot, m_spike, m_state, m_done);
      end
    end
    en = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_sweep();
    test_fire();
    test_accumulate();
    test_back_to_back();
    test_refractory();
    test_threshold_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
